// File: rtl/mem_access_unit_if.sv
// Request/response bus between the datapath and the memory access unit.
// The datapath is the master; the access unit is the slave.
interface mem_access_unit_if;
    logic        req;
    logic        ready;
    logic        wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;

    modport master (output req, wr, funct3, addr, wdata,
                    input  ready, rdata, done, err);
    modport slave  (input  req, wr, funct3, addr, wdata,
                    output ready, rdata, done, err);
endinterface

// File: rtl/mem_access_unit.sv
// Load/store controller for a word-indexed single-port memory: sub-word load
// extraction, read-modify-write sub-word stores, rejection of bad accesses.
module mem_access_unit #(
    parameter int MEM_WORDS = 128
) (
    input  logic                clk,
    input  logic                reset,
    mem_access_unit_if.slave    bus,
    output logic [31:0]         mem_a,
    output logic [31:0]         mem_wd,
    output logic                mem_we,
    input  logic [31:0]         mem_rd
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q;
    logic        ready_q, done_q, err_q, wr_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, buf_q, rdata_q;

    logic        f3_ok, misal, oor, acc_err;
    logic [3:0]  be;
    logic [31:0] wsh, wd_d, rdata_d;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    // Classification of the request presented on the bus this cycle.
    always_comb begin
        f3_ok = bus.wr ? (bus.funct3 inside {3'b000, 3'b001, 3'b010})
                       : (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misal = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
        oor   = {2'b00, bus.addr[31:2]} >= 32'(MEM_WORDS);
        acc_err = !f3_ok || misal || oor;
    end

    // Load extraction straight from the memory read port during READ.
    always_comb begin
        ld_b = mem_rd[{addr_q[1:0], 3'b000} +: 8];
        ld_h = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (f3_q)
            3'b000:  rdata_d = {{24{ld_b[7]}}, ld_b};
            3'b001:  rdata_d = {{16{ld_h[15]}}, ld_h};
            3'b100:  rdata_d = {24'h0, ld_b};
            3'b101:  rdata_d = {16'h0, ld_h};
            default: rdata_d = mem_rd;
        endcase
    end

    // Store merge: replicate the store data across lanes, then pick per lane.
    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                be  = 4'b0001 << addr_q[1:0];
                wsh = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be  = addr_q[1] ? 4'b1100 : 4'b0011;
                wsh = {2{wdata_q[15:0]}};
            end
            default: begin
                be  = 4'b1111;
                wsh = wdata_q;
            end
        endcase
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign wd_d[8*k +: 8] = be[k] ? wsh[8*k +: 8] : buf_q[8*k +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.req) begin
                    wr_q    <= bus.wr;
                    f3_q    <= bus.funct3;
                    addr_q  <= bus.addr;
                    wdata_q <= bus.wdata;
                    ready_q <= 1'b0;
                    if (acc_err) begin
                        state_q <= RESP;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else if (bus.wr && bus.funct3 == 3'b010) begin
                        state_q <= WRITE;
                    end else begin
                        state_q <= READ;
                    end
                end
                READ: begin
                    buf_q <= mem_rd;
                    if (wr_q) begin
                        state_q <= WRITE;
                    end else begin
                        state_q <= RESP;
                        rdata_q <= rdata_d;
                        done_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    state_q <= RESP;
                    done_q  <= 1'b1;
                end
                RESP: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

    // Gating with reset keeps an aborted store from landing in memory.
    assign mem_we = (state_q == WRITE) && !reset;
    assign mem_wd = (state_q == WRITE) ? wd_d : '0;
    assign mem_a  = {2'b00, addr_q[31:2]};
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural memory and a
// reference model of the load/store rules.
module tb_mem_access_unit;
    localparam int MW = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;
    logic        pl_we = 1'b0;
    logic [6:0]  pl_a = '0;
    logic [31:0] pl_d = '0;

    logic [31:0] mem [MW];
    logic [31:0] ref_mem [MW];
    logic [31:0] ref_rdata;
    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit_if bus();

    mem_access_unit #(.MEM_WORDS(MW)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = (mem_a < MW) ? mem[mem_a[6:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_we && mem_a < MW) mem[mem_a[6:0]] <= mem_wd;
        else if (pl_we) mem[pl_a] <= pl_d;
    end

    // Reference: applies an access to ref_mem/ref_rdata, returns error and latency.
    task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic e, output int lat);
        int sz, idx, k;
        logic legal;
        logic [31:0] word;
        byte b;
        shortint h;
        sz = 1 << f3[1:0];
        legal = w ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        e = !legal || (a % sz != 0) || ((a >> 2) >= MW);
        lat = 1;
        if (e) return;
        idx = int'(a >> 2);
        k = int'(a % 4);
        word = ref_mem[idx];
        b = byte'(word >> (8 * k));
        h = shortint'(word >> (16 * (k / 2)));
        if (!w) begin
            lat = 2;
            case (f3)
                3'd0: ref_rdata = 32'(int'(b));
                3'd1: ref_rdata = 32'(int'(h));
                3'd4: ref_rdata = (word >> (8 * k)) & 32'hFF;
                3'd5: ref_rdata = (word >> (16 * (k / 2))) & 32'hFFFF;
                default: ref_rdata = word;
            endcase
        end else begin
            lat = (f3 == 3'd2) ? 2 : 3;
            case (f3)
                3'd0: word[8*k +: 8] = wd[7:0];
                3'd1: word[16*(k/2) +: 16] = wd[15:0];
                default: word = wd;
            endcase
            ref_mem[idx] = word;
        end
    endtask

    // Issues one request and observes the DUT cycle by cycle after the accept edge.
    task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int done_cyc, output logic err_o,
                          output int we_cnt, output int we_cyc, output logic [31:0] a0,
                          output logic a_stable);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.req = 1'b1; bus.wr = w; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
        done_cyc = -1; err_o = 1'bx; we_cnt = 0; we_cyc = -1; a_stable = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        a0 = mem_a;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_we) begin we_cnt++; we_cyc = c; end
            if (mem_a !== a0) a_stable = 1'b0;
            if (bus.done) begin done_cyc = c; err_o = bus.err; break; end
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        @(negedge clk);
        pl_we = 1'b1; pl_a = 7'(idx); pl_d = v;
        ref_mem[idx] = v;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.req = 1'b0; bus.wr = 1'b0; bus.funct3 = 3'd0; bus.addr = '0; bus.wdata = '0;
        for (int i = 0; i < MW; i++) preload(i, $urandom);
        preload(3, 32'h8899AABB);
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        reset = 1'b0;
        ref_rdata = 32'h0;
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", bus.ready); end
        n_cmp++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_done_err got %b%b want 00", bus.done, bus.err); end
        n_cmp++; if (bus.rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", bus.rdata); end
        n_cmp++; if (mem_we !== 1'b0 || mem_wd !== 32'h0 || mem_a !== 32'h0) begin
            n_bad++; $display("FAIL reset_mem got we=%b wd=%h a=%h want 0", mem_we, mem_wd, mem_a); end
    endtask

    task automatic test_loads;
        logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] as  [4] = '{32'h0D, 32'h0D, 32'h0E, 32'h0C};
        logic [31:0] exs [4] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h0000AABB};
        int dc, wc, wcy, lat; logic e, me, st; logic [31:0] a0;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, f3s[i], as[i], 32'h0, dc, e, wc, wcy, a0, st);
            model(1'b0, f3s[i], as[i], 32'h0, me, lat);
            n_cmp++; if (bus.rdata !== exs[i]) begin n_bad++; $display("FAIL load%0d_rdata got %h want %h", i, bus.rdata, exs[i]); end
            n_cmp++; if (dc != 2 || e !== 1'b0 || wc != 0) begin
                n_bad++; $display("FAIL load%0d_timing got done=%0d err=%b we=%0d want 2 0 0", i, dc, e, wc); end
        end
    endtask

    task automatic test_subword_store;
        int dc, wc, wcy, lat; logic e, me, st; logic [31:0] a0;
        run_op(1'b1, 3'd0, 32'h0C, 32'h00000123, dc, e, wc, wcy, a0, st);
        model(1'b1, 3'd0, 32'h0C, 32'h00000123, me, lat);
        n_cmp++; if (mem[3] !== 32'h8899AA23) begin n_bad++; $display("FAIL sb_word got %h want 8899aa23", mem[3]); end
        n_cmp++; if (dc != 3 || wc != 1 || wcy != 2 || e !== 1'b0) begin
            n_bad++; $display("FAIL sb_timing got done=%0d we=%0d@%0d err=%b want 3 1@2 0", dc, wc, wcy, e); end
        n_cmp++; if (a0 !== 32'd3 || !st) begin n_bad++; $display("FAIL sb_mem_a got %h stable=%b want 3 1", a0, st); end
        run_op(1'b1, 3'd1, 32'h0E, 32'h0000BEEF, dc, e, wc, wcy, a0, st);
        model(1'b1, 3'd1, 32'h0E, 32'h0000BEEF, me, lat);
        n_cmp++; if (mem[3] !== 32'hBEEFAA23) begin n_bad++; $display("FAIL sh_word got %h want beefaa23", mem[3]); end
        n_cmp++; if (dc != 3 || wc != 1 || wcy != 2) begin
            n_bad++; $display("FAIL sh_timing got done=%0d we=%0d@%0d want 3 1@2", dc, wc, wcy); end
    endtask

    task automatic test_word_store;
        int dc, wc, wcy, lat; logic e, me, st; logic [31:0] a0;
        run_op(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, dc, e, wc, wcy, a0, st);
        model(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, me, lat);
        n_cmp++; if (a0 !== 32'd4 || !st) begin n_bad++; $display("FAIL sw_mem_a got %h stable=%b want 4 1", a0, st); end
        n_cmp++; if (dc != 2 || wc != 1 || wcy != 1) begin
            n_bad++; $display("FAIL sw_timing got done=%0d we=%0d@%0d want 2 1@1", dc, wc, wcy); end
        run_op(1'b0, 3'd2, 32'h10, 32'h0, dc, e, wc, wcy, a0, st);
        model(1'b0, 3'd2, 32'h10, 32'h0, me, lat);
        n_cmp++; if (bus.rdata !== 32'hDEADBEEF || dc != 2) begin
            n_bad++; $display("FAIL lw_after_sw got %h done=%0d want deadbeef 2", bus.rdata, dc); end
    endtask

    task automatic test_errors;
        logic        ws  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s [5] = '{3'd2, 3'd1, 3'd2, 3'd3, 3'd4};
        logic [31:0] as  [5] = '{32'h06, 32'h03, 32'h200, 32'h08, 32'h08};
        int dc, wc, wcy, lat; logic e, me, st; logic [31:0] a0, rd0;
        for (int i = 0; i < 5; i++) begin
            rd0 = bus.rdata;
            run_op(ws[i], f3s[i], as[i], 32'h12345678, dc, e, wc, wcy, a0, st);
            model(ws[i], f3s[i], as[i], 32'h12345678, me, lat);
            n_cmp++; if (dc != 1 || e !== 1'b1 || wc != 0) begin
                n_bad++; $display("FAIL err%0d got done=%0d err=%b we=%0d want 1 1 0", i, dc, e, wc); end
            n_cmp++; if (bus.rdata !== rd0) begin n_bad++; $display("FAIL err%0d_rdata got %h want %h", i, bus.rdata, rd0); end
        end
    endtask

    task automatic test_reset_in_write;
        int guard, seen;
        logic [31:0] w3;
        w3 = ref_mem[3];
        guard = 0;
        @(negedge clk);
        while (!bus.ready && guard < 20) begin @(negedge clk); guard++; end
        bus.req = 1'b1; bus.wr = 1'b1; bus.funct3 = 3'd0; bus.addr = 32'h0C; bus.wdata = 32'hFF;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_wr_we got %b want 0", mem_we); end
        @(negedge clk);
        reset = 1'b0;
        ref_rdata = 32'h0;
        seen = 0;
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL rst_wr_ready got %b want 1", bus.ready); end
        for (int c = 0; c < 3; c++) begin
            if (bus.done) seen++;
            @(negedge clk);
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_wr_done got %0d pulses want 0", seen); end
        n_cmp++; if (mem[3] !== w3) begin n_bad++; $display("FAIL rst_wr_word got %h want %h", mem[3], w3); end
    endtask

    task automatic test_random;
        int dc, wc, wcy, lat, bad_words; logic e, me, st, w; logic [2:0] f3; logic [31:0] a, wd, a0;
        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, MW * 4 + 31));
            if ($urandom_range(0, 3) != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 : a[1:0] & {1'b1, f3[1:0] == 2'b00};
            wd = $urandom;
            run_op(w, f3, a, wd, dc, e, wc, wcy, a0, st);
            model(w, f3, a, wd, me, lat);
            n_cmp++; if (dc != lat || e !== me || bus.rdata !== ref_rdata) begin
                n_bad++; $display("FAIL rnd%0d w=%b f3=%0d a=%h got done=%0d err=%b rd=%h want %0d %b %h",
                                  i, w, f3, a, dc, e, bus.rdata, lat, me, ref_rdata); end
            n_cmp++; if (wc != ((w && !me) ? 1 : 0) || !st) begin
                n_bad++; $display("FAIL rnd%0d_we got we=%0d stable=%b want %0d 1", i, wc, st, (w && !me) ? 1 : 0); end
        end
        bad_words = 0;
        for (int i = 0; i < MW; i++) if (mem[i] !== ref_mem[i]) bad_words++;
        n_cmp++; if (bad_words != 0) begin n_bad++; $display("FAIL rnd_mem_image got %0d bad words want 0", bad_words); end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  f3s [3] = '{3'd2, 3'd4, 3'd1};
        logic [31:0] as  [3] = '{32'h10, 32'h0D, 32'h0E};
        int dcs [3];
        int idx, lat, guard; logic me;
        guard = 0;
        @(negedge clk);
        while (!bus.ready && guard < 20) begin @(negedge clk); guard++; end
        bus.req = 1'b1; bus.wr = 1'b0; bus.funct3 = f3s[0]; bus.addr = as[0]; bus.wdata = '0;
        idx = 0;
        dcs = '{-100, -200, -300};
        for (int c = 1; c <= 20 && idx < 3; c++) begin
            @(negedge clk);
            if (bus.done) begin
                dcs[idx] = c;
                model(1'b0, f3s[idx], as[idx], 32'h0, me, lat);
                n_cmp++; if (bus.rdata !== ref_rdata || bus.err !== 1'b0) begin
                    n_bad++; $display("FAIL b2b%0d_rdata got %h err=%b want %h 0", idx, bus.rdata, bus.err, ref_rdata); end
                idx++;
                if (idx < 3) begin bus.funct3 = f3s[idx]; bus.addr = as[idx]; end
                else bus.req = 1'b0;
            end
        end
        bus.req = 1'b0;
        n_cmp++; if (dcs[0] != 2) begin n_bad++; $display("FAIL b2b_first got %0d want 2", dcs[0]); end
        n_cmp++; if (dcs[1] - dcs[0] != 3 || dcs[2] - dcs[1] != 3) begin
            n_bad++; $display("FAIL b2b_spacing got %0d %0d want 3 3", dcs[1] - dcs[0], dcs[2] - dcs[1]); end
    endtask

    initial begin
        test_reset;
        test_loads;
        test_subword_store;
        test_word_store;
        test_errors;
        test_reset_in_write;
        test_random;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
